mem_stage: RTL

//  MEM pipeline stage of the RV32I core. It sits downstream of the EX/MEM pipeline register and feeds the MEM/WB register.

---
 rtl/mem_stage.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage -- MEM pipeline stage of the RV32I core.
//
// Sits between the EX/MEM and MEM/WB registers. Runs loads and stores on a
// req/gnt/rvalid data bus: it aligns byte lanes, generates the store byte
// enables and sign- or zero-extends load data. Non-memory instructions pass
// straight through. stall_o freezes PC..EX/MEM while an access is pending.
//
// Ports
//   clk, rst          clock (rising edge), synchronous active-high reset
//   opcode_i          opcode from EX/MEM
//   funct3_i          funct3 from EX/MEM (access size and signedness)
//   rd_we_i           write-back enable from EX/MEM
//   rd_addr_i         destination register from EX/MEM
//   rd_data_i         ALU result: effective address for memory ops, else result
//   rs2_data_i        store data
//   dbus_req          bus request, held until dbus_gnt
//   dbus_we           1 = store, 0 = load
//   dbus_addr         word-aligned bus address
//   dbus_be           byte enables
//   dbus_wdata        lane-replicated store data
//   dbus_gnt          request accepted this cycle
//   dbus_rvalid       load data valid (at least one cycle after gnt)
//   dbus_rdata        load word
//   stall_o           freeze upstream stages this cycle
//   misalign_o        misaligned access detected (single-cycle flag)
//   rd_we_o           write-back enable to MEM/WB
//   rd_addr_o         destination register to MEM/WB
//   rd_data_o         write-back data to MEM/WB
// ---------------------------------------------------------------------------
module mem_stage #(
  parameter logic [6:0] OPC_LOAD  = 7'b0000011,
  parameter logic [6:0] OPC_STORE = 7'b0100011
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  opcode_i,
  input  logic [2:0]  funct3_i,
  input  logic        rd_we_i,
  input  logic [4:0]  rd_addr_i,
  input  logic [31:0] rd_data_i,
  input  logic [31:0] rs2_data_i,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [3:0]  dbus_be,
  output logic [31:0] dbus_wdata,
  input  logic        dbus_gnt,
  input  logic        dbus_rvalid,
  input  logic [31:0] dbus_rdata,
  output logic        stall_o,
  output logic        misalign_o,
  output logic        rd_we_o,
  output logic [4:0]  rd_addr_o,
  output logic [31:0] rd_data_o
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] load_q;

  logic [1:0]  a;
  logic        is_load;
  logic        is_store;
  logic        bad_f3;
  logic        misal;
  logic        legal_mem;

  // Select the addressed byte/half of the bus word and extend it to 32 bits.
  function automatic logic [31:0] fmt_load(input logic [2:0]  f3,
                                           input logic [1:0]  off,
                                           input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = off[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'd0, b};
      3'b101:  return {16'd0, h};
      default: return w;
    endcase
  endfunction

  // Decode, alignment and store lane generation
  always_comb begin
    a        = rd_data_i[1:0];
    is_load  = (opcode_i == OPC_LOAD);
    is_store = (opcode_i == OPC_STORE);

    case (funct3_i[1:0])
      2'b00:   misal = 1'b0;
      2'b01:   misal = a[0];
      default: misal = (a != 2'b00);
    endcase

    if (is_load)
      bad_f3 = (funct3_i == 3'b011) || (funct3_i == 3'b110) || (funct3_i == 3'b111);
    else
      bad_f3 = funct3_i[2] || (funct3_i[1:0] == 2'b11);

    legal_mem = (is_load || is_store) && !bad_f3 && !misal;

    dbus_we   = is_store;
    dbus_addr = {rd_data_i[31:2], 2'b00};
    case (funct3_i[1:0])
      2'b00: begin
        dbus_be    = 4'b0001 << a;
        dbus_wdata = {4{rs2_data_i[7:0]}};
      end
      2'b01: begin
        dbus_be    = 4'b0011 << a;
        dbus_wdata = {2{rs2_data_i[15:0]}};
      end
      default: begin
        dbus_be    = 4'hF;
        dbus_wdata = rs2_data_i;
      end
    endcase
    if (is_load) dbus_be = 4'hF;
  end

  // Next state and outputs
  always_comb begin
    state_nxt  = state;
    dbus_req   = 1'b0;
    stall_o    = 1'b0;
    misalign_o = 1'b0;
    rd_we_o    = 1'b0;
    rd_addr_o  = rd_addr_i;
    rd_data_o  = rd_data_i;

    case (state)
      IDLE: begin
        if (legal_mem) begin
          dbus_req = 1'b1;
          stall_o  = 1'b1;
          if (dbus_gnt) begin
            // A granted store retires in this very cycle.
            if (is_store) stall_o = 1'b0;
            else          state_nxt = WAIT;
          end else begin
            state_nxt = REQ;
          end
        end else if (is_load || is_store) begin
          // Rejected access: flag only genuine misalignment, never write back.
          misalign_o = misal && !bad_f3;
        end else begin
          rd_we_o = rd_we_i;
        end
      end
      REQ: begin
        // EX/MEM is frozen, so the bus fields computed above stay stable.
        dbus_req = 1'b1;
        stall_o  = 1'b1;
        if (dbus_gnt) begin
          if (is_store) begin
            stall_o   = 1'b0;
            state_nxt = IDLE;
          end else begin
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        stall_o = 1'b1;
        if (dbus_rvalid) state_nxt = RESP;
      end
      default: begin
        rd_data_o = load_q;
        rd_we_o   = rd_we_i;
        state_nxt = IDLE;
      end
    endcase

    if (rst) begin
      state_nxt  = IDLE;
      dbus_req   = 1'b0;
      stall_o    = 1'b0;
      misalign_o = 1'b0;
      rd_we_o    = 1'b0;
    end
  end

  // State register and load data capture
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      load_q <= 32'd0;
    end else begin
      state <= state_nxt;
      if (state == WAIT && dbus_rvalid)
        load_q <= fmt_load(funct3_i, a, dbus_rdata);
    end
  end

endmodule
